gpr_wb_arbiter: RTL and testbench

GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

---
 rtl/gpr_wb_arbiter_if.sv | 37 +++
 rtl/gpr_wb_arbiter.sv | 127 ++++++++++++
 tb/tb_gpr_wb_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// GPR writeback arbiter bus: two writeback requesters in, one registered GPR write port out.
// master = requester/observer side, slave = arbiter side.
interface gpr_wb_arbiter_if #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic              ex_wb_req;
   logic [ADDR_W-1:0] ex_wb_addr;
   logic [DATA_W-1:0] ex_wb_data;
   logic              mem_wb_req;
   logic [ADDR_W-1:0] mem_wb_addr;
   logic [DATA_W-1:0] mem_wb_data;
   logic              ex_wb_ack;
   logic              mem_wb_ack;
   logic              gpr_we_;
   logic [ADDR_W-1:0] gpr_wr_addr;
   logic [DATA_W-1:0] gpr_wr_data;
   logic              stall;
   logic [CW-1:0]     pend_cnt;

   modport master (
      output ex_wb_req, ex_wb_addr, ex_wb_data,
      output mem_wb_req, mem_wb_addr, mem_wb_data,
      input  ex_wb_ack, mem_wb_ack,
      input  gpr_we_, gpr_wr_addr, gpr_wr_data, stall, pend_cnt
   );

   modport slave (
      input  ex_wb_req, ex_wb_addr, ex_wb_data,
      input  mem_wb_req, mem_wb_addr, mem_wb_data,
      output ex_wb_ack, mem_wb_ack,
      output gpr_we_, gpr_wr_addr, gpr_wr_data, stall, pend_cnt
   );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// Shares one GPR write port between execute and load writebacks, buffering the overflow in a
// small circular FIFO. Priority per cycle: FIFO head, then load, then execute.
module gpr_wb_arbiter #(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
) (
   input logic             clk,
   input logic             reset,
   gpr_wb_arbiter_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [ADDR_W-1:0] buf_addr_q [DEPTH];
   logic [DATA_W-1:0] buf_data_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              we_n_q, stall_q, stall_d;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   logic              m_keep, e_keep, issue, pop;
   logic [ADDR_W-1:0] iss_addr, enq0_addr, enq1_addr;
   logic [DATA_W-1:0] iss_data, enq0_data, enq1_data;
   logic [1:0]        n_enq;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) return '0;
      return p + PW'(1);
   endfunction

   always_comb begin
      int unsigned tot;
      m_keep    = !reset && bus.mem_wb_req && (bus.mem_wb_addr != '0);
      e_keep    = !reset && bus.ex_wb_req && (bus.ex_wb_addr != '0);
      tot       = 32'(cnt_q) + 32'(m_keep) + 32'(e_keep);
      issue     = (tot != 0);
      // Whatever does not issue this cycle must fit in the FIFO; ex is sacrificed first.
      if (e_keep && (tot - 32'(issue) > DEPTH)) begin
         e_keep = 1'b0;
         tot    = tot - 1;
      end
      if (m_keep && (tot - 32'(issue) > DEPTH)) begin
         m_keep = 1'b0;
         tot    = tot - 1;
      end

      pop       = (cnt_q != '0);
      iss_addr  = '0;
      iss_data  = '0;
      enq0_addr = bus.ex_wb_addr;
      enq0_data = bus.ex_wb_data;
      enq1_addr = bus.ex_wb_addr;
      enq1_data = bus.ex_wb_data;
      n_enq     = 2'd0;
      if (pop) begin
         iss_addr = buf_addr_q[rd_ptr_q];
         iss_data = buf_data_q[rd_ptr_q];
         if (m_keep) begin
            enq0_addr = bus.mem_wb_addr;
            enq0_data = bus.mem_wb_data;
         end
         n_enq = {1'b0, m_keep} + {1'b0, e_keep};
      end else if (m_keep) begin
         iss_addr = bus.mem_wb_addr;
         iss_data = bus.mem_wb_data;
         n_enq    = {1'b0, e_keep};
      end else if (e_keep) begin
         iss_addr = bus.ex_wb_addr;
         iss_data = bus.ex_wb_data;
      end

      wr_ptr_nxt = ptr_inc(wr_ptr_q);
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case (n_enq)
         2'd1:    wr_ptr_d = wr_ptr_nxt;
         2'd2:    wr_ptr_d = ptr_inc(wr_ptr_nxt);
         default: wr_ptr_d = wr_ptr_q;
      endcase
      cnt_d   = cnt_q - CW'(pop) + CW'(n_enq);
      stall_d = (32'(cnt_d) >= DEPTH - 1);
   end

   // x0 requests are acked but otherwise vanish.
   assign bus.mem_wb_ack = !reset && bus.mem_wb_req && ((bus.mem_wb_addr == '0) || m_keep);
   assign bus.ex_wb_ack  = !reset && bus.ex_wb_req && ((bus.ex_wb_addr == '0) || e_keep);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         stall_q  <= 1'b0;
         we_n_q   <= 1'b1;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         stall_q  <= stall_d;
         we_n_q   <= !issue;
         if (issue) begin
            addr_q <= iss_addr;
            data_q <= iss_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (n_enq != 2'd0) begin
         buf_addr_q[wr_ptr_q] <= enq0_addr;
         buf_data_q[wr_ptr_q] <= enq0_data;
      end
      if (n_enq == 2'd2) begin
         buf_addr_q[wr_ptr_nxt] <= enq1_addr;
         buf_data_q[wr_ptr_nxt] <= enq1_data;
      end
   end

   assign bus.gpr_we_     = we_n_q;
   assign bus.gpr_wr_addr = addr_q;
   assign bus.gpr_wr_data = data_q;
   assign bus.stall       = stall_q;
   assign bus.pend_cnt    = cnt_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter (DEPTH=2): inputs driven 1 time unit after each rising edge,
// acks checked 1 unit later, registered outputs checked 1 unit after the next rising edge.
module tb_gpr_wb_arbiter;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   int   mi, ei, nwr;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   logic [ADDR_W+DATA_W-1:0] exp_item;

   gpr_wb_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   gpr_wb_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic m, input logic [4:0] ma, input logic [31:0] md,
                        input logic e, input logic [4:0] ea, input logic [31:0] ed);
      bus.mem_wb_req  = m;
      bus.mem_wb_addr = ma;
      bus.mem_wb_data = md;
      bus.ex_wb_req   = e;
      bus.ex_wb_addr  = ea;
      bus.ex_wb_data  = ed;
   endtask

   task automatic chk_acks(input string tag, input logic m, input logic e);
      #1;
      chk({tag, "_mem_ack"}, 64'(bus.mem_wb_ack), 64'(m));
      chk({tag, "_ex_ack"}, 64'(bus.ex_wb_ack), 64'(e));
   endtask

   task automatic chk_out(input string tag, input logic we_n, input logic [4:0] a,
                          input logic [31:0] d, input int pend, input logic st);
      chk({tag, "_we_"}, 64'(bus.gpr_we_), 64'(we_n));
      chk({tag, "_addr"}, 64'(bus.gpr_wr_addr), 64'(a));
      chk({tag, "_data"}, 64'(bus.gpr_wr_data), 64'(d));
      chk({tag, "_pend"}, 64'(bus.pend_cnt), 64'(pend));
      chk({tag, "_stall"}, 64'(bus.stall), 64'(st));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
      chk_acks("rst_req", 1'b0, 1'b0);
      tick();
      chk_out("rst", 1'b1, 5'd0, 32'd0, 0, 1'b0);
      tick();
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk_out("idle", 1'b1, 5'd0, 32'd0, 0, 1'b0);

      // Single write with one-cycle latency, then hold.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55);
      chk_acks("single", 1'b0, 1'b1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk_out("single_t1", 1'b0, 5'd5, 32'h55, 0, 1'b0);
      tick();
      chk_out("single_t2", 1'b1, 5'd5, 32'h55, 0, 1'b0);

      // x0 requests are acked and vanish.
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
      chk_acks("x0", 1'b0, 1'b1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk_out("x0_t1", 1'b1, 5'd5, 32'h55, 0, 1'b0);

      // Same-register collision: mem first, ex last.
      drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
      chk_acks("coll", 1'b1, 1'b1);
      tick();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk_out("coll_t1", 1'b0, 5'd3, 32'hA, 1, 1'b1);
      tick();
      chk_out("coll_t2", 1'b0, 5'd3, 32'hB, 0, 1'b0);
      tick();
      chk_out("coll_t3", 1'b1, 5'd3, 32'hB, 0, 1'b0);

      // Backpressure: both held three cycles, ex dropped in the third.
      drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd2, 32'h200);
      chk_acks("bp_c0", 1'b1, 1'b1);
      tick();
      chk_out("bp_c0", 1'b0, 5'd1, 32'h100, 1, 1'b1);
      drive(1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h201);
      chk_acks("bp_c1", 1'b1, 1'b1);
      tick();
      chk_out("bp_c1", 1'b0, 5'd2, 32'h200, 2, 1'b1);
      drive(1'b1, 5'd1, 32'h102, 1'b1, 5'd2, 32'h202);
      chk_acks("bp_c2", 1'b1, 1'b0);
      tick();
      chk_out("bp_c2", 1'b0, 5'd1, 32'h101, 2, 1'b1);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      chk_out("bp_c3", 1'b0, 5'd2, 32'h201, 1, 1'b1);
      tick();
      chk_out("bp_c4", 1'b0, 5'd1, 32'h102, 0, 1'b0);
      tick();
      chk_out("bp_c5", 1'b1, 5'd1, 32'h102, 0, 1'b0);

      // Wrap-around: 10 mem + 10 ex items, each held until acked, written in acceptance order.
      mi  = 0;
      ei  = 0;
      nwr = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         if (mi == 10 && ei == 10 && exp_q.size() == 0) break;
         drive(mi < 10, 5'(mi + 1), 32'h1000 + 32'(mi), ei < 10, 5'(ei + 11), 32'h2000 + 32'(ei));
         #1;
         if (mi < 10 && bus.mem_wb_ack) begin
            exp_q.push_back({5'(mi + 1), 32'h1000 + 32'(mi)});
            mi++;
         end
         if (ei < 10 && bus.ex_wb_ack) begin
            exp_q.push_back({5'(ei + 11), 32'h2000 + 32'(ei)});
            ei++;
         end
         tick();
         if (bus.gpr_we_ == 1'b0) begin
            nwr++;
            if (exp_q.size() == 0) begin
               chk("wrap_extra_write", 64'(nwr), 64'd0);
            end else begin
               exp_item = exp_q.pop_front();
               chk("wrap_write", 64'({bus.gpr_wr_addr, bus.gpr_wr_data}), 64'(exp_item));
            end
         end
         chk("wrap_pend_le2", 64'(bus.pend_cnt <= 2), 64'd1);
      end
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk("wrap_nwr", 64'(nwr), 64'd20);
      chk("wrap_mem_done", 64'(mi), 64'd10);
      chk("wrap_ex_done", 64'(ei), 64'd10);
      tick();
      chk_out("wrap_idle", 1'b1, 5'd20, 32'h2009, 0, 1'b0);

      // Reset flush with two buffered entries.
      drive(1'b1, 5'd4, 32'h40, 1'b1, 5'd5, 32'h50);
      tick();
      drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'h70);
      tick();
      chk_out("flush_pre", 1'b0, 5'd5, 32'h50, 2, 1'b1);
      reset = 1'b1;
      chk_acks("flush_rst", 1'b0, 1'b0);
      tick();
      chk_out("flush_rst", 1'b1, 5'd0, 32'd0, 0, 1'b0);
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_out("flush_after", 1'b1, 5'd0, 32'd0, 0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
